// File: rtl/ntt_rd_addr_gen.sv
// ============================================================================
// Module  : ntt_rd_addr_gen
// Purpose : Read address, bank routing and twiddle sequencer for a 4-bank,
//           two-butterfly NTT (forward CT / inverse GS).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module ntt_rd_addr_gen #(
    parameter  int ADDR_WIDTH = 6,
    localparam int W          = ADDR_WIDTH + 2,
    localparam int SW         = $clog2(W)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic                  en,
    output logic [ADDR_WIDTH-1:0] rd_addr0,
    output logic [ADDR_WIDTH-1:0] rd_addr1,
    output logic [ADDR_WIDTH-1:0] rd_addr2,
    output logic [ADDR_WIDTH-1:0] rd_addr3,
    output logic [1:0]            sel_a_0,
    output logic [1:0]            sel_a_1,
    output logic [1:0]            sel_a_2,
    output logic [1:0]            sel_a_3,
    output logic [W-1:0]          tw0,
    output logic [W-1:0]          tw1,
    output logic [SW-1:0]         stage,
    output logic                  valid,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_n;

    logic [SW-1:0]         k;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  mode_q;
    logic                  fin;
    logic                  armed;
    logic                  accept;
    logic                  issue;
    logic [SW-1:0]         k_last;

    logic [SW-1:0]         k_partner;
    logic [SW-1:0]         pair_lo;
    logic [W-1:0]          cnt_ext;
    logic [W-1:0]          lo_mask;
    logic [W-1:0]          base;
    logic [W-1:0]          bit_k;
    logic [W-1:0]          bit_m;
    logic [W-1:0]          slot_idx [4];
    logic [ADDR_WIDTH-1:0] addr_n   [4];
    logic [1:0]            sel_n    [4];
    logic [W-1:0]          tw_base;
    logic [W-1:0]          tw0_n;
    logic [W-1:0]          tw1_n;

    // Bank = {parity of odd index bits, parity of even index bits}
    function automatic logic [1:0] bank_of(input logic [W-1:0] idx);
        logic odd_p;
        logic even_p;
        odd_p  = 1'b0;
        even_p = 1'b0;
        for (int b = 0; b < W; b++) begin
            if ((b % 2) == 1) odd_p  = odd_p ^ idx[b];
            else              even_p = even_p ^ idx[b];
        end
        return {odd_p, even_p};
    endfunction

    // Slot index generation: k and its partner k^1 form an aligned bit pair,
    // so counter bits at or above the pair simply move up by two.
    always_comb begin
        k_partner   = k ^ SW'(1);
        pair_lo     = {k[SW-1:1], 1'b0};
        cnt_ext     = W'(cnt);
        lo_mask     = (W'(1) << pair_lo) - W'(1);
        base        = ((cnt_ext & ~lo_mask) << 2) | (cnt_ext & lo_mask);
        bit_k       = W'(1) << k;
        bit_m       = W'(1) << k_partner;
        slot_idx[0] = base;
        slot_idx[1] = base | bit_k;
        slot_idx[2] = base | bit_m;
        slot_idx[3] = base | bit_k | bit_m;
    end

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            addr_n[b] = '0;
            sel_n[b]  = '0;
        end
        for (int s = 0; s < 4; s++) begin
            addr_n[bank_of(slot_idx[s])] = slot_idx[s][W-1:2];
            sel_n[bank_of(slot_idx[s])]  = 2'(s);
        end
    end

    always_comb begin
        tw_base = W'(1) << (SW'(W - 1) - k);
        tw0_n   = tw_base + (slot_idx[0] >> ({1'b0, k} + (SW + 1)'(1)));
        tw1_n   = tw_base + (slot_idx[2] >> ({1'b0, k} + (SW + 1)'(1)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // fin marks that the final issue has been presented; RUN is held for
    // that last valid cycle so done lands on the following cycle.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        issue   = 1'b0;
        case (state)
            IDLE: begin
                if (start && armed) begin
                    accept  = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (fin)     state_n = DONE;
                else if (en) issue   = 1'b1;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign k_last = mode_q ? SW'(W - 1) : '0;
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k        <= '0;
            cnt      <= '0;
            mode_q   <= 1'b0;
            fin      <= 1'b0;
            armed    <= 1'b0;
            valid    <= 1'b0;
            stage    <= '0;
            rd_addr0 <= '0;
            rd_addr1 <= '0;
            rd_addr2 <= '0;
            rd_addr3 <= '0;
            sel_a_0  <= '0;
            sel_a_1  <= '0;
            sel_a_2  <= '0;
            sel_a_3  <= '0;
            tw0      <= '0;
            tw1      <= '0;
        end else begin
            // Blocks a start that coincides with reset release
            armed <= 1'b1;
            valid <= issue;
            if (accept) begin
                k      <= mode ? '0 : SW'(W - 1);
                cnt    <= '0;
                mode_q <= mode;
                fin    <= 1'b0;
            end
            if (issue) begin
                stage    <= k;
                rd_addr0 <= addr_n[0];
                rd_addr1 <= addr_n[1];
                rd_addr2 <= addr_n[2];
                rd_addr3 <= addr_n[3];
                sel_a_0  <= sel_n[0];
                sel_a_1  <= sel_n[1];
                sel_a_2  <= sel_n[2];
                sel_a_3  <= sel_n[3];
                tw0      <= tw0_n;
                tw1      <= tw1_n;
                cnt      <= cnt + ADDR_WIDTH'(1);
                if (&cnt) begin
                    if (k == k_last) fin <= 1'b1;
                    else if (mode_q) k   <= k + SW'(1);
                    else             k   <= k - SW'(1);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ntt_rd_addr_gen.sv
// Directed bench for ntt_rd_addr_gen: transaction-level model of the issue
// sequence, per-cycle output comparison, and an index-coverage scoreboard.
`timescale 1ns/1ps
`default_nettype none

module tb_ntt_rd_addr_gen;

    localparam int AW = 6;
    localparam int W  = AW + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          mode_in = 1'b0;
    logic          en = 1'b1;
    logic [AW-1:0] rd_addr0, rd_addr1, rd_addr2, rd_addr3;
    logic [1:0]    sel_a_0, sel_a_1, sel_a_2, sel_a_3;
    logic [W-1:0]  tw0, tw1;
    logic [2:0]    stage;
    logic          valid, busy, done;

    ntt_rd_addr_gen #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode_in), .en(en),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_addr3(rd_addr3),
        .sel_a_0(sel_a_0), .sel_a_1(sel_a_1), .sel_a_2(sel_a_2), .sel_a_3(sel_a_3),
        .tw0(tw0), .tw1(tw1), .stage(stage), .valid(valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [AW-1:0] ra [4];
    logic [1:0]    sa [4];
    assign ra[0] = rd_addr0;
    assign ra[1] = rd_addr1;
    assign ra[2] = rd_addr2;
    assign ra[3] = rd_addr3;
    assign sa[0] = sel_a_0;
    assign sa[1] = sel_a_1;
    assign sa[2] = sel_a_2;
    assign sa[3] = sel_a_3;

    logic [50:0] dut_vec;
    assign dut_vec = {rd_addr0, rd_addr1, rd_addr2, rd_addr3,
                      sel_a_0, sel_a_1, sel_a_2, sel_a_3, tw0, tw1, stage};

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int bank_int(input int i);
        int odd_p = 0;
        int even_p = 0;
        for (int b = 0; b < W; b++) begin
            if (((i >> b) & 1) == 1) begin
                if ((b % 2) == 1) odd_p = odd_p ^ 1;
                else              even_p = even_p ^ 1;
            end
        end
        return odd_p * 2 + even_p;
    endfunction

    // Expected outputs for issue (k, c), straight from the index/bank rules
    function automatic logic [50:0] model_pack(input int k, input int c);
        int m = k ^ 1;
        int a = 0;
        int pos = 0;
        int idx [4];
        int bk, t0, t1;
        logic [AW-1:0] ad [4];
        logic [1:0]    sl [4];
        for (int b = 0; b < W; b++) begin
            if (b != k && b != m) begin
                a = a | (((c >> pos) & 1) << b);
                pos++;
            end
        end
        idx[0] = a;
        idx[1] = a | (1 << k);
        idx[2] = a | (1 << m);
        idx[3] = a | (1 << k) | (1 << m);
        for (int s = 0; s < 4; s++) begin
            bk     = bank_int(idx[s]);
            ad[bk] = AW'(idx[s] / 4);
            sl[bk] = 2'(s);
        end
        t0 = ((1 << (W - 1 - k)) + (idx[0] >> (k + 1))) % (1 << W);
        t1 = ((1 << (W - 1 - k)) + (idx[2] >> (k + 1))) % (1 << W);
        return {ad[0], ad[1], ad[2], ad[3], sl[0], sl[1], sl[2], sl[3],
                8'(t0), 8'(t1), 3'(k)};
    endfunction

    int          q[$];
    logic [50:0] last_exp = '0;
    bit          chk = 1'b0;
    bit          done_due = 1'b0;
    bit          exp_done;
    int          nvalid = 0;
    int          ndone = 0;
    int          gaps = 0;
    int          run_mode = 0;
    int          seen [W * 256];
    int          e_cur;
    logic [7:0]  hi, rec;
    logic [1:0]  bb;
    logic [3:0]  selmask;

    always @(negedge clk) begin
        if (chk) begin
            exp_done = done_due;
            done_due = 1'b0;
            if (valid) begin
                if (q.size() == 0) begin
                    check("extra_valid", 64'(valid), 64'd0);
                end else begin
                    e_cur    = q.pop_front();
                    last_exp = model_pack(e_cur / 64, e_cur % 64);
                    selmask  = '0;
                    for (int b = 0; b < 4; b++) begin
                        bb  = 2'(b);
                        hi  = {ra[b], 2'b00};
                        rec = hi | {6'd0, bb[1] ^ (^(hi & 8'hAA)), bb[0] ^ (^(hi & 8'h55))};
                        seen[(e_cur / 64) * 256 + int'(rec)]++;
                        selmask[sa[b]] = 1'b1;
                    end
                    check("sel_distinct", 64'(selmask), 64'hF);
                    if (run_mode == 0 && nvalid == 0)
                        check("fwd_first_issue", 64'(dut_vec),
                              64'({6'd0, 6'd16, 6'd32, 6'd48, 2'b00, 2'b10, 2'b01, 2'b11, 8'd1, 8'd1, 3'd7}));
                    if (run_mode == 0 && nvalid == 449)
                        check("fwd_k0_c1_issue", 64'(dut_vec),
                              64'({6'd1, 6'd1, 6'd1, 6'd1, 2'b01, 2'b00, 2'b11, 2'b10, 8'd130, 8'd131, 3'd0}));
                    if (run_mode == 1 && nvalid == 0)
                        check("inv_first_issue", 64'(dut_vec),
                              64'({6'd0, 6'd0, 6'd0, 6'd0, 2'b00, 2'b01, 2'b10, 2'b11, 8'd128, 8'd129, 3'd0}));
                    nvalid++;
                    if (q.size() == 0) done_due = 1'b1;
                end
            end else if (nvalid > 0 && q.size() > 0) begin
                gaps++;
            end
            check("outputs", 64'(dut_vec), 64'(last_exp));
            check("done", 64'(done), 64'(exp_done));
            if (done) ndone++;
        end
    end

    task automatic do_run(input int md, input bit stall);
        bit stalled = 1'b0;
        int errs = 0;
        for (int i = 0; i < W * 256; i++) seen[i] = 0;
        nvalid   = 0;
        ndone    = 0;
        gaps     = 0;
        run_mode = md;
        q.delete();
        for (int s = 0; s < W; s++)
            for (int c = 0; c < 64; c++)
                q.push_back((md == 0 ? (W - 1 - s) : s) * 64 + c);
        start   = 1'b1;
        mode_in = md[0];
        @(posedge clk); #1;
        start   = 1'b0;
        mode_in = ~md[0];
        @(negedge clk);
        check("accept_latency", {62'd0, valid, busy}, 64'd1);
        for (int n = 0; n < 2000 && ndone == 0; n++) begin
            @(posedge clk); #1;
            if (stall && !stalled && nvalid == 70) begin
                stalled = 1'b1;
                en = 1'b0;
                repeat (2) @(posedge clk);
                #1 start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
                repeat (2) @(posedge clk);
                #1 en = 1'b1;
            end
        end
        if (ndone == 0) check("run_timeout", 64'(ndone), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("valid_count", 64'(nvalid), 64'd512);
        check("done_count", 64'(ndone), 64'd1);
        check("stall_gaps", 64'(gaps), stall ? 64'd5 : 64'd0);
        check("busy_after_run", 64'(busy), 64'd0);
        for (int i = 0; i < W * 256; i++) if (seen[i] != 1) errs++;
        check("index_coverage", 64'(errs), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {10'd0, dut_vec, valid, busy, done}, 64'd0);
        rst = 1'b1;
        chk = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_run(0, 1'b0);
        do_run(1, 1'b0);
        do_run(0, 1'b1);

        // Abort mid-run, then release reset with start already high
        q.delete();
        for (int c = 0; c < 512; c++) q.push_back((W - 1 - c / 64) * 64 + c % 64);
        run_mode = 2;
        start = 1'b1;
        mode_in = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk = 1'b0;
        rst = 1'b0;
        #1;
        check("reset_mid_run", {10'd0, dut_vec, valid, busy, done}, 64'd0);
        q.delete();
        last_exp = '0;
        done_due = 1'b0;
        @(posedge clk); #1;
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("start_at_release_ignored", {62'd0, busy, valid}, 64'd0);
        do_run(0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
